// File: rtl/seq_detector_if.sv
// Serial-sample bus of the sequence detector: sample/control inputs from the
// producer side, registered match flag and match count back from the detector.
interface seq_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             En;
    logic             w;
    logic             Load;
    logic [N-1:0]     Pat_in;
    logic             Clr_cnt;
    logic             z;
    logic [CNT_W-1:0] Count;

    modport master (
        output En, w, Load, Pat_in, Clr_cnt,
        input  z, Count
    );

    modport slave (
        input  En, w, Load, Pat_in, Clr_cnt,
        output z, Count
    );
endinterface

// File: rtl/seq_detector.sv
// Moore serial pattern detector with runtime-loadable pattern, optional
// overlapping matches and a saturating, clearable match counter.
module seq_detector #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    seq_detector_if.slave bus
);
    localparam int            SW      = $clog2(N + 1);
    localparam logic [SW-1:0] S_MATCH = SW'(N);

    logic [SW-1:0]    s_q, s_d, s_next;
    logic [N-1:0]     pat_q, pat_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N:0]       cand, pref, mask;
    int               len, s_int;
    logic             hit;

    // Candidate C is right-aligned: its last bit (w) sits at bit 0, so the
    // last k bits of C line up with the first k pattern bits shifted down.
    always_comb begin
        s_int  = int'(s_q);
        s_next = '0;
        pref   = '0;
        mask   = '0;
        if (OVERLAP == 0 && s_q == S_MATCH) begin
            cand = {{N{1'b0}}, bus.w};
            len  = 1;
        end else begin
            cand = (({1'b0, pat_q} >> (N - s_int)) << 1) | {{N{1'b0}}, bus.w};
            len  = s_int + 1;
        end
        for (int k = 1; k <= N; k++) begin
            pref = {1'b0, pat_q} >> (N - k);
            mask = ~({(N + 1){1'b1}} << k);
            if (k <= len && ((cand ^ pref) & mask) == '0) s_next = SW'(k);
        end
    end

    always_comb begin
        pat_d = pat_q;
        s_d   = s_q;
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (bus.Load) begin
            pat_d = bus.Pat_in;
            s_d   = '0;
        end else if (bus.En) begin
            s_d = s_next;
            hit = (s_next == S_MATCH);
        end
        // A clear wins over a coinciding match, which is then not counted.
        if (bus.Clr_cnt)
            cnt_d = '0;
        else if (hit && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        z_d = (s_d == S_MATCH);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s_q   <= '0;
            pat_q <= PATTERN;
            z_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            pat_q <= pat_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.z     = z_q;
    assign bus.Count = cnt_q;
endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: three instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream; expected values are hand-derived.
module tb_seq_detector;
    logic       clk;
    logic       rstn;
    logic       en, w, load, clr;
    logic [3:0] pat_in;

    int n_vec = 0;
    int n_err = 0;

    seq_detector_if #(.N(4), .CNT_W(8)) if0 ();
    seq_detector_if #(.N(4), .CNT_W(8)) if1 ();
    seq_detector_if #(.N(4), .CNT_W(2)) if2 ();

    assign if0.En = en;  assign if0.w = w;  assign if0.Load = load;
    assign if0.Pat_in = pat_in;  assign if0.Clr_cnt = clr;
    assign if1.En = en;  assign if1.w = w;  assign if1.Load = load;
    assign if1.Pat_in = pat_in;  assign if1.Clr_cnt = clr;
    assign if2.En = en;  assign if2.w = w;  assign if2.Load = load;
    assign if2.Pat_in = pat_in;  assign if2.Clr_cnt = clr;

    seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_ov (
        .Clock(clk), .Resetn(rstn), .bus(if0.slave));
    seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_nov (
        .Clock(clk), .Resetn(rstn), .bus(if1.slave));
    seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2)) u_sat (
        .Clock(clk), .Resetn(rstn), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        en = 1'b1;
        w  = b;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic idle();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
    endtask

    task automatic load_pat(input logic [3:0] p);
        load   = 1'b1;
        pat_in = p;
        en     = 1'b1;
        w      = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0;
        en   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; w = 1'b1; load = 1'b0; clr = 1'b0; pat_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", 32'(if0.z), 0);
        check("reset_cnt", 32'(if0.Count), 0);
        check("reset_cnt_sat", 32'(if2.Count), 0);
        en = 1'b0;
        rstn = 1'b1;

        // Basic 1101 detection and one-cycle pulse
        send(1); send(1); send(0);
        check("basic_z_before", 32'(if0.z), 0);
        send(1);
        check("basic_z", 32'(if0.z), 1);
        check("basic_cnt", 32'(if0.Count), 1);
        check("basic_cnt_nov", 32'(if1.Count), 1);
        send(0);
        check("basic_z_fall", 32'(if0.z), 0);

        // 1101101: overlapping vs non-overlapping
        pulse_reset();
        send(1); send(1); send(0); send(1);
        check("ov_z_bit4", 32'(if0.z), 1);
        send(1); send(0);
        check("ov_z_bit6", 32'(if0.z), 0);
        send(1);
        check("ov_z_bit7", 32'(if0.z), 1);
        check("ov_cnt", 32'(if0.Count), 2);
        check("nov_z_bit7", 32'(if1.z), 0);
        check("nov_cnt", 32'(if1.Count), 1);

        // Same stream with runtime pattern 1011
        pulse_reset();
        load_pat(4'b1011);
        send(1); send(1); send(0); send(1); send(1);
        check("p1011_z_bit5", 32'(if0.z), 1);
        send(0); send(1);
        check("p1011_cnt_ov", 32'(if0.Count), 1);
        check("p1011_cnt_nov", 32'(if1.Count), 1);

        // 11101: fallback from s=2 on a 1 stays at s=2
        pulse_reset();
        send(1); send(1); send(1); send(0);
        check("fb_z_bit4", 32'(if0.z), 0);
        send(1);
        check("fb_z_bit5", 32'(if0.z), 1);
        check("fb_cnt", 32'(if0.Count), 1);

        // Gaps in En
        pulse_reset();
        send(1);
        w = 1'b0; idle();
        w = 1'b1; idle();
        check("gap_z_idle", 32'(if0.z), 0);
        send(1); send(0); send(1);
        check("gap_z", 32'(if0.z), 1);
        w = 1'b0; idle(); idle();
        check("gap_z_hold", 32'(if0.z), 1);
        check("gap_cnt", 32'(if0.Count), 1);

        // Load 0000; the sample on the load edge is discarded
        pulse_reset();
        load_pat(4'b0000);
        send(0); send(0); send(0);
        check("zero_z_bit3", 32'(if0.z), 0);
        send(0);
        check("zero_z_bit4", 32'(if0.z), 1);
        check("zero_cnt4", 32'(if0.Count), 1);
        send(0);
        check("zero_z_bit5", 32'(if0.z), 1);
        check("zero_cnt5", 32'(if0.Count), 2);
        check("zero_nov_z5", 32'(if1.z), 0);
        check("zero_nov_cnt5", 32'(if1.Count), 1);

        // Saturation of the 2-bit counter and clear priority
        pulse_reset();
        load_pat(4'b0000);
        for (int i = 0; i < 6; i++) send(0);
        check("sat_cnt6", 32'(if2.Count), 3);
        send(0); send(0);
        check("sat_cnt8", 32'(if2.Count), 3);
        check("sat_cnt8_wide", 32'(if0.Count), 5);
        clr = 1'b1;
        send(0);
        clr = 1'b0;
        check("clr_cnt", 32'(if0.Count), 0);
        check("clr_cnt_sat", 32'(if2.Count), 0);
        check("clr_z", 32'(if0.z), 1);
        send(0);
        check("clr_after", 32'(if0.Count), 1);

        // Reset mid-sequence abandons the partial match
        pulse_reset();
        send(1); send(1); send(0); send(1);
        send(1); send(1); send(0);
        check("mid_cnt_before", 32'(if0.Count), 1);
        rstn = 1'b0;
        #2;
        check("mid_async_cnt", 32'(if0.Count), 0);
        rstn = 1'b1;
        send(1);
        check("mid_z_after", 32'(if0.z), 0);
        check("mid_cnt_after", 32'(if0.Count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
